// File: rtl/imem_pkg.sv
// Shared types and width helpers for the instruction memory fetch unit.
// Keeps the byte-lane and index width math in one place.
package imem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int lsb_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, single-port-read synchronous RAM, read-first.
// The read register only updates when re is set, so it doubles as a hold stage.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with registered fetch port, valid/ready handshake,
// program-load port and a post-reset clear sequencer.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int              DATA_W       = 32,
  parameter int              DEPTH        = 256,
  parameter int              ADDR_W       = 64,
  parameter logic [DATA_W-1:0] FAULT_WORD = '0,
  parameter bit              CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = lsb_w(DATA_W);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int TOP   = LSB + IDX_W;

  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'(BYTES - 1);

  function automatic logic oor(
    input logic [ADDR_W-1:0] a
  );
    return (a >> TOP) != '0;
  endfunction

  function automatic logic [IDX_W-1:0] idx(
    input logic [ADDR_W-1:0] a
  );
    return a[TOP-1:LSB];
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic              fault_now;
  logic              can_accept;
  logic              has_data;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RST ? CLEAR : RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: begin
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + IDX_W'(1);
    end
  end

  assign fault_now =
    ((fetch_addr & LOW_MASK) != '0) ||
    oor(fetch_addr);
  assign can_accept = !fetch_valid || fetch_ready;

  // While clearing, the counter owns the write port and loads are dropped.
  always_comb begin
    busy      = (state == CLEAR);
    fetch_gnt = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = idx(load_addr);
    ram_wdata = load_data;
    ram_raddr = idx(fetch_addr);
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = cnt;
      ram_wdata = '0;
    end else begin
      fetch_gnt = fetch_req && can_accept;
      ram_we    = load_en && !oor(load_addr);
    end
    ram_re = fetch_gnt && !fault_now;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      has_data    <= 1'b0;
    end else if (fetch_gnt) begin
      fetch_valid <= 1'b1;
      fetch_fault <= fault_now;
      has_data    <= 1'b1;
    end else if (fetch_ready) begin
      fetch_valid <= 1'b0;
    end
  end

  // A faulting fetch leaves the RAM read register untouched.
  always_comb begin
    fetch_data = ram_rdata;
    if (!has_data) begin
      fetch_data = '0;
    end else if (fetch_fault) begin
      fetch_data = FAULT_WORD;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: vector table, hand sequences
// and a randomized phase against an array-based reference model.
module tb_imem_fetch_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 64;
  localparam logic [31:0] FW = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic          fetch_ready = 1'b1;
  logic [DW-1:0] fetch_data;
  logic          fetch_fault;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          busy;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .ADDR_W       (AW),
    .FAULT_WORD   (FW),
    .CLEAR_ON_RST (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy)
  );

  typedef struct {
    bit          ld;
    logic [63:0] addr;
    logic [31:0] d;
    logic [31:0] ed;
    bit          ef;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    fetch_req  = 1'b1;
    fetch_addr = 64'h0;
    load_en    = 1'b1;
    load_addr  = 64'h20;
    load_data  = 32'h1234_5678;
    while (busy && n < 400) begin
      #1;
      chk({nm, " gnt while busy"}, fetch_gnt, 1'b0);
      n++;
      tick;
    end
    fetch_req = 1'b0;
    load_en   = 1'b0;
    chk({nm, " busy cycles"}, n, 256);
  endtask

  task automatic load1(input logic [63:0] a,
                       input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick;
    load_en = 1'b0;
  endtask

  task automatic fetch1(input string nm,
                        input logic [63:0] a,
                        input logic [31:0] ed,
                        input bit ef);
    fetch_req   = 1'b1;
    fetch_addr  = a;
    fetch_ready = 1'b1;
    #1;
    chk({nm, " gnt"}, fetch_gnt, 1'b1);
    tick;
    fetch_req = 1'b0;
    chk({nm, " valid"}, fetch_valid, 1'b1);
    chk({nm, " data"}, fetch_data, ed);
    chk({nm, " fault"}, fetch_fault, ef);
  endtask

  logic [31:0] mdl [DEPTH];

  function automatic logic [63:0] rnd_addr();
    int r = $urandom_range(0, 9);
    logic [63:0] base = 64'($urandom_range(0, 15)) * 4;
    if (r == 7) return base + 64'($urandom_range(1, 3));
    if (r == 8) return base + 64'd1024;
    if (r == 9) return base | 64'h8000_0000_0000_0000;
    return base;
  endfunction

  initial begin
    bit mv;
    logic [31:0] md;
    bit mf;

    vecs[0]  = '{1, 64'h8,   32'h0050_0093, 32'h0, 0};
    vecs[1]  = '{0, 64'h8,   32'h0, 32'h0050_0093, 0};
    vecs[2]  = '{0, 64'h6,   32'h0, FW, 1};
    vecs[3]  = '{0, 64'h400, 32'h0, FW, 1};
    vecs[4]  = '{0, 64'h20,  32'h0, 32'h0, 0};
    vecs[5]  = '{1, 64'hB,   32'hCAFE_F00D, 32'h0, 0};
    vecs[6]  = '{0, 64'h8,   32'h0, 32'hCAFE_F00D, 0};
    vecs[7]  = '{1, 64'h404, 32'h5555_5555, 32'h0, 0};
    vecs[8]  = '{0, 64'h4,   32'h0, 32'h0, 0};
    vecs[9]  = '{0, 64'h8,   32'h0, 32'hCAFE_F00D, 0};
    vecs[10] = '{1, 64'h10,  32'h0000_0005, 32'h0, 0};
    vecs[11] = '{0, 64'h10,  32'h0, 32'h0000_0005, 0};
    vecs[12] = '{0, 64'h8000_0000_0000_0008,
                 32'h0, FW, 1};

    // Reset and first clear
    rst_n = 1'b0;
    repeat (3) tick;
    chk("rst valid", fetch_valid, 1'b0);
    chk("rst fault", fetch_fault, 1'b0);
    chk("rst data", fetch_data, 32'h0);
    chk("rst busy", busy, 1'b1);
    rst_n = 1'b1;
    count_busy("clear1");
    chk("run busy", busy, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].ld) begin
        load1(vecs[i].addr, vecs[i].d);
      end else begin
        fetch1($sformatf("vec%0d", i), vecs[i].addr,
               vecs[i].ed, vecs[i].ef);
      end
    end

    // Back-to-back fetches
    load1(64'h0, 32'hA1A1_A1A1);
    load1(64'h4, 32'hB2B2_B2B2);
    load1(64'h8, 32'hC3C3_C3C3);
    fetch_ready = 1'b1;
    fetch_req   = 1'b1;
    fetch_addr  = 64'h0;
    #1 chk("b2b gnt0", fetch_gnt, 1'b1);
    tick;
    chk("b2b d0", fetch_data, 32'hA1A1_A1A1);
    fetch_addr = 64'h4;
    #1 chk("b2b gnt1", fetch_gnt, 1'b1);
    tick;
    chk("b2b v1", fetch_valid, 1'b1);
    chk("b2b d1", fetch_data, 32'hB2B2_B2B2);
    fetch_addr = 64'h8;
    #1 chk("b2b gnt2", fetch_gnt, 1'b1);
    tick;
    chk("b2b v2", fetch_valid, 1'b1);
    chk("b2b d2", fetch_data, 32'hC3C3_C3C3);
    fetch_req = 1'b0;
    tick;
    chk("drain valid", fetch_valid, 1'b0);
    chk("drain hold", fetch_data, 32'hC3C3_C3C3);

    // Stall with load to the stalled word
    fetch1("stall pre", 64'h8, 32'hC3C3_C3C3, 0);
    fetch_ready = 1'b0;
    fetch_req   = 1'b1;
    fetch_addr  = 64'h0;
    for (int i = 0; i < 3; i++) begin
      load_en   = (i == 1);
      load_addr = 64'h8;
      load_data = 32'h1111_1111;
      #1 chk("stall gnt", fetch_gnt, 1'b0);
      tick;
      chk("stall valid", fetch_valid, 1'b1);
      chk("stall data", fetch_data, 32'hC3C3_C3C3);
    end
    load_en     = 1'b0;
    fetch_ready = 1'b1;
    fetch_addr  = 64'h8;
    #1 chk("unstall gnt", fetch_gnt, 1'b1);
    tick;
    chk("refetch data", fetch_data, 32'h1111_1111);

    // Same-cycle load and fetch, read-first
    load_en    = 1'b1;
    load_addr  = 64'h10;
    load_data  = 32'hAAAA_AAAA;
    fetch_addr = 64'h10;
    #1 chk("rf gnt", fetch_gnt, 1'b1);
    tick;
    chk("rf old", fetch_data, 32'h0000_0005);
    load_en = 1'b0;
    #1 chk("rf gnt2", fetch_gnt, 1'b1);
    tick;
    chk("rf new", fetch_data, 32'hAAAA_AAAA);
    fetch_req = 1'b0;

    // Reset in the middle of the clear sequence
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (100) tick;
    chk("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    tick;
    chk("mid rst busy", busy, 1'b1);
    chk("mid rst valid", fetch_valid, 1'b0);
    rst_n = 1'b1;
    count_busy("clear2");

    // Randomized run against the model
    foreach (mdl[i]) mdl[i] = 32'h0;
    mv = 0;
    md = 32'h0;
    mf = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] a;
      logic [63:0] la;
      bit flt;
      bit eg;
      a           = rnd_addr();
      la          = rnd_addr();
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_addr  = a;
      fetch_ready = ($urandom_range(0, 2) != 0);
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = la;
      load_data   = $urandom;
      flt = (a % 4 != 0) || (a >= 64'd1024);
      eg  = fetch_req && (!mv || fetch_ready);
      #1 chk("rnd gnt", fetch_gnt, eg);
      if (eg) begin
        mv = 1;
        mf = flt;
        md = flt ? FW : mdl[a / 4];
      end else if (fetch_ready) begin
        mv = 0;
      end
      if (load_en && la < 64'd1024) begin
        mdl[la / 4] = load_data;
      end
      tick;
      chk("rnd valid", fetch_valid, mv);
      chk("rnd data", fetch_data, md);
      if (mv) chk("rnd fault", fetch_fault, mf);
    end
    fetch_req = 1'b0;
    load_en   = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
